// File: rtl/float_div_pkg.sv
// Shared definitions for the float divider stages: IEEE-754 single-precision
// field widths, the multiplier pipeline depth and the operand class decode.
package float_div_pkg;

  localparam int FLT_W   = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int MUL_LAT = 5;

  // Class of a single-precision value; the four classes are mutually exclusive.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
  } flt_flags_t;

  // Classifies a value from its magnitude bits (sign excluded, it never
  // changes the class). Normal numbers return all flags clear.
  function automatic flt_flags_t flt_classify(input logic [FLT_W-2:0] mag);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             e_ones;
    logic             e_zero;
    logic             m_zero;
    flt_flags_t       f;
    e        = mag[FLT_W-2 -: EXP_W];
    m        = mag[MAN_W-1:0];
    e_ones   = &e;
    e_zero   = ~|e;
    m_zero   = ~|m;
    f.nan    = e_ones & ~m_zero;
    f.inf    = e_ones &  m_zero;
    f.zero   = e_zero &  m_zero;
    f.denorm = e_zero & ~m_zero;
    return f;
  endfunction

endpackage

// File: rtl/float_div_drain_fifo.sv
// Circular result buffer for the multiplier drain stage. Exposes its
// occupancy so the parent can reserve space for results still in flight.
module float_div_drain_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             full;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready;

  // Storage write.
  // NOTE: the array has no reset; an empty FIFO never exposes it because the
  // read port below is gated by out_valid, so reset only needs the pointers.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers
  // wrap by plain overflow.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head word; reads as zero while empty (no write-to-read bypass).
  assign rdata = out_valid ? mem[rd_ptr] : '0;

  // The parent's stall reservation must make an overflowing push impossible.
  a_no_overflow : assert property (@(posedge aclk) disable iff (!arst_n) !(push && full));

endmodule

// File: rtl/float_div_mul_drain.sv
// Drain stage behind the pipelined multiplier: tracks which pipeline slots
// carry real operations, captures each result exactly once into a tagged,
// classified FIFO, and stalls the multiplier before any result could be lost.
module float_div_mul_drain
  import float_div_pkg::*;
#(
  parameter int LAT   = MUL_LAT,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [FLT_W-1:0] x,
  output logic             astall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int ENT_W = FLT_W + TAG_W + $bits(flt_flags_t);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LAT + 1);

  // Reserving a slot per in-flight result only works if an empty FIFO can
  // absorb a full pipeline; the pointers also rely on power-of-two wrap.
  if (LAT < 1 || DEPTH < LAT + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("float_div_mul_drain: need LAT >= 1, DEPTH >= LAT+1, DEPTH power of two");
  end

  logic             en;
  logic [LAT-1:0]   vld;
  logic [TAG_W-1:0] tag_q [LAT];
  logic             push;
  flt_flags_t       cls;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] inflight;

  assign en = ~astall;

  // Valid bits shift in lockstep with the multiplier registers.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      vld <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // Tags ride alongside; unreset because vld qualifies every slot.
  always_ff @(posedge aclk) begin
    if (en) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The last slot is aligned with x; a frozen x is taken only on the first
  // enabled edge, which is what makes capture exactly-once across stalls.
  assign push  = en & vld[LAT-1];
  assign cls   = flt_classify(x[FLT_W-2:0]);
  assign wdata = {x, tag_q[LAT-1], cls};

  float_div_drain_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .push      (push),
    .wdata     (wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdata     (rdata),
    .count     (count)
  );

  assign {out_data, out_tag, out_flags} = rdata;

  // Stall when buffered plus in-flight results could fill the FIFO. Built only
  // from registers, so neither out_ready nor in_valid reaches astall.
  assign inflight = SUM_W'($countones(vld));
  assign astall   = (SUM_W'(count) + inflight) >= SUM_W'(DEPTH);

endmodule

// File: tb/tb_float_div_mul_drain.sv
// Bench for float_div_mul_drain: models the multiplier pipeline as a stallable
// delay line and predicts outputs from a queue of issued operations.
module tb_float_div_mul_drain;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic        aclk;
  logic        arst_n;
  logic        in_valid;
  logic [3:0]  in_tag;
  logic [31:0] x;
  logic        astall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  float_div_mul_drain #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(4)) dut (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .x         (x),
    .astall    (astall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Every issued, not yet consumed operation in issue order; age counts the
  // enabled edges seen since (and including) the issuing edge.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [3:0]  flags;
    int          age;
  } exp_t;

  exp_t        q[$];
  logic [31:0] pipe [LAT];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // {nan, inf, zero, denorm} straight from the exponent/mantissa rules.
  function automatic logic [3:0] ref_flags(input logic [31:0] v);
    int unsigned e = (v >> 23) & 32'hFF;
    int unsigned m = v & 32'h7F_FFFF;
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  // Random value biased toward the special classes.
  function automatic logic [31:0] rand_val();
    logic [31:0] r = $urandom;
    case ($urandom % 8)
      0:       return {r[31], 31'h7F80_0000};
      1:       return {r[31], 8'hFF, r[22:0] | 23'h1};
      2:       return {r[31], 31'h0};
      3:       return {r[31], 8'h00, r[22:0] | 23'h1};
      default: return r;
    endcase
  endfunction

  task automatic compare_outputs();
    logic ev = (q.size() != 0) && (q[0].age > LAT);
    check("astall", astall, q.size() >= DEPTH);
    check("out_valid", out_valid, ev);
    if (ev) begin
      check("out_data", out_data, q[0].data);
      check("out_tag", out_tag, q[0].tag);
      check("out_flags", out_flags, q[0].flags);
    end
  endtask

  // One clock: check at the falling edge, drive, then advance the multiplier
  // and the expectation model according to what the rising edge accepted.
  task automatic step(input logic iv, input logic [3:0] itag, input logic [31:0] ival,
                      input logic rdy, output logic fired);
    logic en;
    logic pop;
    compare_outputs();
    in_valid  = iv;
    in_tag    = itag;
    out_ready = rdy;
    en    = !astall;
    pop   = out_valid && rdy;
    fired = iv && en;
    @(posedge aclk);
    #1;
    if (pop) begin
      if (q.size() == 0) check("pop_empty", 1, 0);
      else q.delete(0);
    end
    if (en) begin
      foreach (q[i]) if (q[i].age <= LAT) q[i].age++;
      if (fired) q.push_back('{data: ival, tag: itag, flags: ref_flags(ival), age: 1});
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = iv ? ival : $urandom;
    end
    x = pipe[LAT-1];
    @(negedge aclk);
  endtask

  task automatic issue_op(input logic [31:0] v, input logic [3:0] t, input logic rdy);
    logic f;
    int   n = 0;
    do begin
      step(1'b1, t, v, rdy, f);
      n++;
    end while (!f && n < 64);
    if (!f) check("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, rdy, f);
  endtask

  task automatic drain();
    logic f;
    int   n = 0;
    while (q.size() != 0 && n < 200) begin
      step(1'b0, 4'h0, 32'h0, 1'b1, f);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    idle(2, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_vals [8];
    logic [31:0] cur_v;
    logic [3:0]  cur_t;
    logic        f;
    logic        iv;
    logic        rdy;
    int          idx;

    arst_n    = 1'b0;
    in_valid  = 1'b0;
    in_tag    = 4'h0;
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) pipe[i] = $urandom;
    x = pipe[LAT-1];
    #1;
    check("rst_astall", astall, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    repeat (3) @(negedge aclk);
    arst_n = 1'b1;

    // Single issue: visible LAT+1 cycles later as a normal number.
    issue_op(32'h4000_0000, 4'd3, 1'b1);
    idle(10, 1'b1);

    // Back-to-back with an always-ready consumer.
    for (int i = 0; i < 20; i++) issue_op(rand_val(), 4'(i), 1'b1);
    drain();

    // Backpressure: slot 3 is the one parked at the pipeline tail during the stall.
    for (int i = 0; i < 3; i++) bp_vals[i] = rand_val();
    bp_vals[3] = 32'h7F80_0000;
    bp_vals[4] = 32'h7FC0_0000;
    bp_vals[5] = 32'h8000_0000;
    bp_vals[6] = 32'h0000_0001;
    bp_vals[7] = rand_val();
    idx   = 0;
    cur_v = bp_vals[0];
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 4'(idx), cur_v, 1'b0, f);
      if (f) begin
        idx++;
        cur_v = (idx < 8) ? bp_vals[idx] : rand_val();
      end
    end
    drain();

    // Random traffic; the issuer holds its operand until accepted.
    cur_v = rand_val();
    cur_t = 4'($urandom);
    for (int c = 0; c < 400; c++) begin
      iv  = ($urandom % 4) != 0;
      rdy = ($urandom % 3) != 0;
      step(iv, cur_t, cur_v, rdy, f);
      if (f) begin
        cur_v = rand_val();
        cur_t = 4'($urandom);
      end
    end
    drain();

    // Reset with 5 buffered and 3 in flight.
    for (int i = 0; i < 5; i++) issue_op(rand_val(), 4'(i), 1'b0);
    idle(6, 1'b0);
    for (int i = 0; i < 3; i++) issue_op(rand_val(), 4'(8 + i), 1'b0);
    in_valid = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    check("midrst_astall", astall, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    q.delete();
    @(negedge aclk);
    arst_n = 1'b1;
    idle(20, 1'b1);
    issue_op(32'h3F80_0000, 4'd9, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_div_mul_drain.md
# float_div_mul_drain

Result-drain stage directly downstream of the 5-stage pipelined IEEE-754 single-precision multiplier in the float divider. Tracks which multiplier pipeline slots hold real operations and captures each result exactly once. Buffers results, with a tag and a class decode, in a small FIFO presented on a valid/ready interface. Generates the multiplier's global `astall` so that no in-flight result can ever be lost.

## Interface
- `LAT`, 5, multiplier register stages; must match the multiplier instance.
- `DEPTH`, 8, result FIFO entries; power of two, `DEPTH >= LAT+1` (elaboration error otherwise).
- `TAG_W`, 4, width of the opaque tag carried alongside each operation.
- `aclk`  in  1  clock; all state on the rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands presented to the multiplier this cycle; counted only when `astall`=0.
- `in_tag`  in  `TAG_W`  tag for the issued operation.
- `x`  in  32  multiplier result bus.
- `astall`  out  1  stall to the multiplier and issuer; upstream must hold operands while high.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  32  result word.
- `out_tag`  out  `TAG_W`  tag of the result.
- `out_flags`  out  4  {nan, inf, zero, denorm} of `out_data`.

## Operation
- `en` = ~`astall`. All slot-tracking state advances only when `en`=1, in lockstep with the multiplier registers.
- Slot tracker:
  - `vld[LAT-1:0]` and `tag[LAT-1:0]` shift registers.
  - On `en`: `vld[0]` <= `in_valid`, `tag[0]` <= `in_tag`; slot i <= slot i-1.
  - `vld[LAT-1]` is aligned with `x`.
- Capture:
  - On an edge with `en`=1 and `vld[LAT-1]`=1, push {`x`, `tag[LAT-1]`, flags(`x`)} into the FIFO.
  - No capture while stalled. The frozen `x` is captured at the next enabled edge, exactly once.
- Flag decode on push (e = `x[30:23]`, m = `x[22:0]`):
  - nan: e=FF, m!=0.
  - inf: e=FF, m=0.
  - zero: e=0, m=0.
  - denorm: e=0, m!=0.
  - At most one flag is set.
- FIFO:
  - Circular; `count` ranges 0..`DEPTH`.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - No write-to-read bypass.
- Stall generation:
  - `astall` = (`count` + popcount(`vld`)) >= `DEPTH`, decoded from registers only.
  - No combinational path from `out_ready` or `in_valid` to `astall`.
  - This reservation guarantees that a push never hits a full FIFO. An overflow is an assertion failure.
- Reset, async or mid-operation:
  - `vld`, `count` and pointers are cleared; FIFO contents are discarded.
  - Multiplier datapath registers are not reset. Their contents are ignored because `vld`=0.

## Timing
- Reset values: `astall`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_flags`=0.
- Unstalled latency: operation issued in cycle c (`in_valid`=1, `astall`=0) → `x` valid in c+`LAT` → `out_valid` in c+`LAT`+1.
- Each cycle of `astall` delays every in-flight result by one cycle.
- Sustained throughput is one result per cycle while `out_ready`=1.
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- Deadlock freedom:
  - With `count`=0, popcount(`vld`) <= `LAT` < `DEPTH`, so `astall`=0.
  - A draining consumer therefore always releases the stall.
- Ordering: results leave in issue order; tags are never reordered.

## Structure
- Shared package `float_div_pkg`:
  - constants `FLT_W`=32, `EXP_W`=8, `MAN_W`=23, `MUL_LAT`=5.
  - struct `flt_flags_t` {nan, inf, zero, denorm}.
  - function `flt_classify` (shared with other divider stages).
- One sub-module, `float_div_drain_fifo`:
  - parameterised by width and `DEPTH`.
  - exposes `count` for the stall computation.
- Slot tracker, capture and stall logic stay in the top module.

## Test plan
- Reset then single issue: `x`=0x40000000 with tag 3 at c → `out_valid` at c+6, data 0x40000000, tag 3, flags 0000; `astall` stays 0.
- Back-to-back: 20 issues, `out_ready`=1 → 20 in-order results, one per cycle, tags 0..19 mod 16, `astall` never rises.
- Backpressure: `out_ready`=0, continuous issue → `astall` rises once `count`+inflight=8; exactly 8 results are eventually buffered; releasing `out_ready` drains all 8 in order, then stall drops.
- Mid-stall alignment: force stall with `vld[4]`=1 and `x`=0x7F800000 held 3 cycles → single push on release with flags inf, no duplicate.
- Classification: results 0x7FC00000, 0x80000000, 0x00000001 → flags nan, zero, denorm respectively.
- Reset with 3 in flight and 5 buffered → `out_valid`=0 and `astall`=0 immediately; no stale result emerges afterwards.
